// File: rtl/serial_collect_pkg.sv
// Shared definitions for the serial_collect bit-serial word collector.
`ifndef SERIAL_COLLECT_PKG_SV
`define SERIAL_COLLECT_PKG_SV
package serial_collect_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int cnt_width(input int way);
    return $clog2(way + 1);
  endfunction

endpackage
`endif

// File: rtl/serial_collect_ctrl.sv
// Handshake FSM and bit counter for serial_collect; drives the shift-register controls.
module serial_collect_ctrl
  import serial_collect_pkg::*;
#(
  parameter int WAY   = 3,
  parameter int CNT_W = cnt_width(WAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             shift_en,
  output logic             load_first,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WAY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count_nx;
  logic             accept, handoff;

  // clr blanks both handshakes so neither an accept nor a handoff can slip through it
  assign in_ready   = rst_n & ~clr & ((state == ST_FILL) | out_ready);
  assign out_valid  = (state == ST_HOLD) & ~clr;
  assign accept     = in_valid & in_ready;
  assign handoff    = out_valid & out_ready;
  assign shift_en   = accept;
  assign load_first = accept & (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    if (clr) begin
      state_nx = ST_FILL;
      count_nx = '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (count == CNT_LAST) begin
              state_nx = ST_HOLD;
              count_nx = CNT_FULL;
            end else begin
              count_nx = count + CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          // A single-bit word is already complete on the bit that rides along with the handoff
          if (handoff && accept) begin
            state_nx = (WAY == 1) ? ST_HOLD : ST_FILL;
            count_nx = (WAY == 1) ? CNT_FULL : CNT_ONE;
          end else if (handoff) begin
            state_nx = ST_FILL;
            count_nx = '0;
          end
        end
        default: begin
          state_nx = ST_FILL;
          count_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_collect.sv
// Collects WAY serial bits into a word for the serial_and tree; first bit lands in e1[WAY-1].
// Define SERIAL_COLLECT_AND_EN to add the running-AND output out_and.
module serial_collect
  import serial_collect_pkg::*;
#(
  parameter int WAY   = 3,
  parameter int CNT_W = cnt_width(WAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WAY-1:0]   e1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
`ifdef SERIAL_COLLECT_AND_EN
  , output logic           out_and
`endif
);

  logic           shift_en, load_first, handoff;
  logic [WAY-1:0] word, shifted;

  serial_collect_ctrl #(.WAY(WAY), .CNT_W(CNT_W)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .shift_en   (shift_en),
    .load_first (load_first),
    .count      (count)
  );

  assign handoff = out_valid & out_ready;

  generate
    if (WAY == 1) begin : gen_single
      assign shifted = in_bit;
    end else begin : gen_shift
      assign shifted = {word[WAY-2:0], in_bit};
    end
  endgenerate

  // load_first restarts the word from the bit accepted alongside a handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (load_first) begin
      word <= WAY'(in_bit);
    end else if (shift_en) begin
      word <= shifted;
    end else if (handoff) begin
      word <= '0;
    end
  end

  assign e1 = word;

`ifdef SERIAL_COLLECT_AND_EN
  logic and_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q <= 1'b1;
    end else if (clr) begin
      and_q <= 1'b1;
    end else if (load_first) begin
      and_q <= in_bit;
    end else if (shift_en) begin
      and_q <= and_q & in_bit;
    end else if (handoff) begin
      and_q <= 1'b1;
    end
  end

  assign out_and = and_q;
`endif

endmodule

// File: doc/serial_collect.md
# serial_collect

Bit-serial input collector that sits directly upstream of the `serial_and` reduction tree. It accepts one bit per cycle under a valid/ready handshake and assembles WAY bits into a word. It presents that word on `e1` with a valid/ready handoff, so the combinational tree downstream always sees a stable, complete operand. With continuous input it sustains one bit per cycle, with no bubble between words.

## Interface
- `WAY`, default 3: word width in bits; legal range WAY >= 1; must match the downstream tree's WAY.
- `CNT_W`, default $clog2(WAY+1): width of `count`; derived, not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of the word in progress.
- `in_bit`  in  1  serial data bit.
- `in_valid`  in  1  `in_bit` is valid.
- `in_ready`  out  1  collector accepts `in_bit` this cycle.
- `e1`  out  WAY  collected word; meaningful only while `out_valid`=1.
- `out_valid`  out  1  `e1` holds a complete word.
- `out_ready`  in  1  downstream consumes `e1` this cycle.
- `count`  out  CNT_W  number of bits held, 0..WAY.
- `out_and`  out  1  running AND of the word; present only with SERIAL_COLLECT_AND_EN.

## Operation
- Accept: `in_valid & in_ready`. Handoff: `out_valid & out_ready`.
- FSM has two states, FILL and HOLD.
  - FILL: `in_ready`=1, `out_valid`=0. On accept, `word <= {word[WAY-2:0], in_bit}` and `count++`. If the bit is the WAY-th, go to HOLD.
  - HOLD: `out_valid`=1, `in_ready`=`out_ready`. `e1` and `count`=WAY are frozen until handoff.
  - On handoff without accept: word=0, count=0, go to FILL.
  - On handoff with accept in the same cycle: word={0…,in_bit}, count=1, go to FILL. If WAY==1, stay in HOLD with the new bit.
- Bit order: the first accepted bit ends at `e1[WAY-1]` and the last at `e1[0]`. Bits not yet written read 0.
- `clr` has priority over everything except reset.
  - Effect: word=0, count=0, state FILL.
  - In the `clr` cycle, `in_ready`=0 and `out_valid`=0; no accept and no handoff occur.
- Reset (async, mid-operation included): word=0, count=0, state FILL, out_and=1, `out_valid`=0. `in_ready`=0 while `rst_n`=0 and 1 after release.
- `in_valid` with `in_ready`=0: the bit is not consumed; the source must hold it.
- `count` never exceeds WAY, and never wraps.

## Timing
- `e1`, `count`, `out_valid` and `out_and` are registered. `in_ready` is combinational from state, `out_ready`, `clr` and `rst_n`.
- `out_valid` rises on the clock edge that accepts the WAY-th bit, so it is visible the following cycle.
- Latency: first bit accepted at cycle t gives `out_valid` at t+WAY, with continuous input.
- Throughput: one word per WAY cycles when `in_valid` and `out_ready` are held high.
- The combinational path `out_ready`→`in_ready` is intentional. Upstream must not make `in_valid` depend on `in_ready`.

## Configuration
- Macro: `SERIAL_COLLECT_AND_EN`.
- Defined: adds the `out_and` output and its register.
  - Set to 1 on reset, `clr`, and on handoff without accept.
  - On accept it becomes `out_and & in_bit`, or just `in_bit` for the first bit of a word.
  - Equals &`e1` whenever `out_valid`=1, which lets the consumer bypass the tree.
- Undefined: port and register are absent. The reduction is done only by the downstream `serial_and`.

## Structure
- Shared header, include-guarded: state encodings ST_FILL and ST_HOLD.
- Natural sub-module: `serial_collect_ctrl`, containing the FSM and the counter. It outputs `in_ready`, `out_valid`, `shift_en`, `load_first` and `count`.
- The shift register and the optional AND register stay in the top level.
- The bench instantiates `serial_and` on `e1` as a reference for `out_and`.

## Test plan
- Reset mid-word: after bits 1,1 (WAY=3), pull `rst_n` low asynchronously → `count`=0, `e1`=0, `out_valid`=0 immediately; `in_ready`=1 after release.
- Stream 1,0,1 with `out_ready`=1 → `e1`=3'b101 and `out_valid`=1 for one cycle, three cycles after the first accept; `out_and`=0.
- Stream 1,1,1, then hold `out_ready`=0 for 4 cycles with `in_valid`=1 → `in_ready`=0 and `e1`=3'b111 frozen, `out_and`=1. Then `out_ready`=1 with `in_bit`=0 → handoff, bit accepted, `count`=1.
- Six continuous bits 1,1,0,0,1,1 with `out_ready`=1 → words 3'b110 then 3'b011; `out_valid` asserted once every 3 cycles; no dropped bits.
- `clr` after 2 bits, then 0,1,1 → `e1`=3'b011; the earlier bits are discarded; `in_ready`=0 during the `clr` cycle.
- WAY=1, bits 1,0 continuous with `out_ready`=1 → `out_valid` stays high, `e1` is 1 then 0 on consecutive cycles.
